// File: rtl/sap_pkg.sv
// Shared definitions for the SAP control sequencer: opcodes, one-hot T-states
// and control-word bit positions.
package sap_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_JMP = 4'h3,
    OP_JC  = 4'h4,
    OP_JZ  = 4'h5,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam int CW_CP  = 0;
  localparam int CW_EP  = 1;
  localparam int CW_LP  = 2;
  localparam int CW_MI  = 3;
  localparam int CW_RO  = 4;
  localparam int CW_II  = 5;
  localparam int CW_IO  = 6;
  localparam int CW_AI  = 7;
  localparam int CW_AO  = 8;
  localparam int CW_BI  = 9;
  localparam int CW_EO  = 10;
  localparam int CW_SU  = 11;
  localparam int CW_FI  = 12;
  localparam int CW_OI  = 13;
  localparam int CW_HLT = 14;
  localparam int CW_W   = 15;

  typedef logic [CW_W-1:0] cw_t;

endpackage

// File: rtl/sap_microcode_decode.sv
// Combinational microcode: T-state, opcode and flags to control word, plus a
// flag marking the instruction's final active T-state.
module sap_microcode_decode
  import sap_pkg::*;
(
  input  tstate_e    t_state,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output cw_t        cw,
  output logic       last
);

  always_comb begin
    cw   = '0;
    last = 1'b0;
    case (t_state)
      T1: begin
        cw[CW_EP] = 1'b1;
        cw[CW_MI] = 1'b1;
      end
      T2: cw[CW_CP] = 1'b1;
      T3: begin
        cw[CW_RO] = 1'b1;
        cw[CW_II] = 1'b1;
      end
      T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_IO] = 1'b1;
            cw[CW_MI] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_AO] = 1'b1;
            cw[CW_OI] = 1'b1;
            last      = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IO] = 1'b1;
            cw[CW_LP] = 1'b1;
            last      = 1'b1;
          end
          OP_JC: begin
            cw[CW_IO] = 1'b1;
            cw[CW_LP] = flag_c;
            last      = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IO] = 1'b1;
            cw[CW_LP] = flag_z;
            last      = 1'b1;
          end
          // HLT is not "last": the top freezes the ring here instead.
          OP_HLT:  cw[CW_HLT] = 1'b1;
          default: last = 1'b1;
        endcase
      end
      T5: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RO] = 1'b1;
            cw[CW_AI] = 1'b1;
            last      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RO] = 1'b1;
            cw[CW_BI] = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        last = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_EO] = 1'b1;
          cw[CW_AI] = 1'b1;
          cw[CW_FI] = 1'b1;
          cw[CW_SU] = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP CPU control sequencer: one-hot T-state ring, halt latch, run/reset
// gating of the microcode control word.
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter bit EARLY_END = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       cp,
  output logic       ep,
  output logic       lp,
  output logic       mi,
  output logic       ro,
  output logic       ii,
  output logic       io,
  output logic       ai,
  output logic       ao,
  output logic       bi,
  output logic       eo,
  output logic       su,
  output logic       fi,
  output logic       oi,
  output logic       hlt,
  output logic [5:0] t_state
);

  tstate_e t_state_q, t_state_d;
  logic    halt_q, halt_d;
  cw_t     cw_dec, cw_out;
  logic    last;
  logic    halting;

  sap_microcode_decode u_decode (
    .t_state (t_state_q),
    .opcode  (opcode),
    .flag_c  (flag_c),
    .flag_z  (flag_z),
    .cw      (cw_dec),
    .last    (last)
  );

  assign halting = (t_state_q == T4) && (opcode == OP_HLT);

  always_comb begin
    t_state_d = t_state_q;
    halt_d    = halt_q;
    if (run && !halt_q) begin
      if (halting) begin
        halt_d = 1'b1;
      end else if (EARLY_END && last) begin
        t_state_d = T1;
      end else begin
        case (t_state_q)
          T1:      t_state_d = T2;
          T2:      t_state_d = T3;
          T3:      t_state_d = T4;
          T4:      t_state_d = T5;
          T5:      t_state_d = T6;
          default: t_state_d = T1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_state_q <= T1;
      halt_q    <= 1'b0;
    end else begin
      t_state_q <= t_state_d;
      halt_q    <= halt_d;
    end
  end

  // Reset gating is combinational so strobes drop the moment rst_n falls.
  always_comb begin
    cw_out = '0;
    if (rst_n && run) begin
      if (halt_q) cw_out[CW_HLT] = 1'b1;
      else        cw_out = cw_dec;
    end
  end

  assign cp      = cw_out[CW_CP];
  assign ep      = cw_out[CW_EP];
  assign lp      = cw_out[CW_LP];
  assign mi      = cw_out[CW_MI];
  assign ro      = cw_out[CW_RO];
  assign ii      = cw_out[CW_II];
  assign io      = cw_out[CW_IO];
  assign ai      = cw_out[CW_AI];
  assign ao      = cw_out[CW_AO];
  assign bi      = cw_out[CW_BI];
  assign eo      = cw_out[CW_EO];
  assign su      = cw_out[CW_SU];
  assign fi      = cw_out[CW_FI];
  assign oi      = cw_out[CW_OI];
  assign hlt     = cw_out[CW_HLT];
  assign t_state = t_state_q;

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the 4-bit SAP-style CPU: the initiator that drives the program counter's `lp`/`cp`/`ep` controls and all other bus-load and bus-enable strobes. A T-state ring counter steps each instruction through fetch (T1–T3) and execute (T4–T6). Control strobes are decoded from the current T-state, the instruction register opcode and the ALU flags. It sits beside the instruction register and drives every datapath block on the shared bus.

## Interface
Parameters:
- `EARLY_END`, default 1: when 1, the ring returns to T1 right after an instruction's last active T-state. When 0, every instruction takes all six T-states.

Ports (clock and reset first):
- `clk` input 1: single system clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `run` input 1: clock enable. When 0, state holds and all strobes are 0.
- `opcode` input 4: upper nibble of the instruction register, registered upstream.
- `flag_c`, `flag_z` inputs 1 each: carry and zero from the flags register.
- `cp`, `ep`, `lp` outputs 1 each: PC count, PC bus-enable, PC load.
- `mi` output 1: memory address register load.
- `ro` output 1: RAM bus-enable.
- `ii` output 1: instruction register load.
- `io` output 1: instruction register operand bus-enable.
- `ai`, `ao` outputs 1 each: A register load and A register bus-enable.
- `bi` output 1: B register load.
- `eo`, `su` outputs 1 each: ALU bus-enable and subtract select.
- `fi` output 1: flags register load.
- `oi` output 1: output register load.
- `hlt` output 1: halted indicator.
- `t_state` output 6: one-hot current T-state, bit 0 = T1.

All strobes are active-high.

## Operation
- Opcodes:
  - LDA = 0x0, ADD = 0x1, SUB = 0x2, JMP = 0x3, JC = 0x4, JZ = 0x5, OUT = 0xE, HLT = 0xF.
  - All other opcodes are NOPs.
- Fetch strobes, identical for every instruction:
  - T1: `ep`, `mi`.
  - T2: `cp`.
  - T3: `ro`, `ii`.
- Execute strobes (T4 / T5 / T6):
  - LDA: `io`,`mi` / `ro`,`ai` / none.
  - ADD: `io`,`mi` / `ro`,`bi` / `eo`,`ai`,`fi`.
  - SUB: same as ADD, with `su` also asserted in T6.
  - OUT: `ao`,`oi` / none / none.
  - JMP: `io`,`lp` / none / none.
  - JC: `io` in T4; `lp` in T4 only if `flag_c`=1. JZ is the same using `flag_z`.
  - HLT: `hlt` in T4; the state freezes at T4.
  - NOP: none.
- Last active T-state:
  - LDA: T5.
  - ADD and SUB: T6.
  - OUT, JMP, JC, JZ and NOP: T4.
  - With `EARLY_END`=1 the next state after the last active T-state is T1. Otherwise the ring advances T1→…→T6→T1.
- Halt:
  - Once in HLT at T4, the state stays at T4 and `hlt`=1 until reset.
  - While halted, all other strobes are 0, regardless of `run`.
- Bus rule: at most one of `ep`, `ro`, `io`, `ao`, `eo` is 1 in any cycle.
- `run`=0 gates every strobe to 0, including `hlt`, and holds `t_state`. When `run` returns to 1, execution resumes in the same T-state.

## Timing
- Strobes are combinational from the registered T-state, `opcode` and flags. They are valid before the next rising edge; datapath blocks act on that edge.
- `opcode` is sampled combinationally each cycle. It is stable from T4 onward because the IR loads at the end of T3.
- Flags are sampled in T4 of JC/JZ. A jump takes effect when the PC loads at the end of T4.
- Reset, asserted at any time, including mid-instruction or while halted:
  - `t_state` = 6'b000001 immediately.
  - The halt latch clears.
  - All strobes are forced to 0 while `rst_n`=0.
  - T1 strobes appear in the first cycle after deassertion.
- Instruction lengths with `EARLY_END`=1: 5 cycles for LDA, 6 for ADD/SUB, 4 for OUT/JMP/JC/JZ/NOP. With `EARLY_END`=0, all instructions take 6 cycles.

## Structure
- Shared package `sap_pkg` holds:
  - the opcode constants;
  - the T-state one-hot constants T1–T6;
  - the control-word bit indices, so the word can be carried as a single bus.
- Sub-module `sap_microcode_decode`: purely combinational mapping of (`t_state`, `opcode`, `flag_c`, `flag_z`) to the control word plus a `last` flag.
- The top level holds the ring counter, the halt latch, the `run` and reset gating, and the `EARLY_END` next-state selection.

## Test plan
- Fetch/LDA: reset, release, `run`=1, `opcode`=0x0 → T1 `ep`+`mi`, T2 `cp`, T3 `ro`+`ii`, T4 `io`+`mi`, T5 `ro`+`ai`, then T1 on cycle 6 (`EARLY_END`=1).
- SUB: `opcode`=0x2 → T6 shows `eo`, `ai`, `fi`, `su` all 1. Repeat with `EARLY_END`=0 and LDA → T6 has no strobes and T1 follows.
- Conditional jump: JC with `flag_c`=0 → T4 `io`=1, `lp`=0. JC with `flag_c`=1 → `lp`=1. Same two checks for JZ with `flag_z`.
- HLT: `opcode`=0xF → state stuck at `t_state`=6'b001000 with `hlt`=1 for 20 cycles. Pulse `rst_n` low → `t_state`=6'b000001 and all strobes 0.
- `run` gating: drop `run` at T2 for 3 cycles → `cp` stays 0 and `t_state` holds. On restore, `cp` pulses once.
- Random opcodes and flags for 10k cycles → the bus-rule assertion (at most one bus-enable) never fires.
